vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Pixel-timing generator for the 640x480 @ 60 Hz VGA path. It sits directly upstream of the display top level. It advances horizontal and vertical counters on each pixel strobe, and produces sync, pixel coordinates, active-video flags, and frame/line event pulses. The top-level colour logic consumes its x/y outputs. Animation logic uses its frame pulse.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_ACTIVE, 0, logic level of o_hs/o_vs while sync is asserted (0 = active-low)

Ports:
i_clk  input  1  system clock (100 MHz)
i_rst  input  1  reset, asynchronous, active-high
i_pix_stb  input  1  pixel strobe; counters advance only in i_clk cycles where it is 1 (25 MHz rate)
o_hs  output  1  horizontal sync
o_vs  output  1  vertical sync
o_x  output  10  pixel column, 0..H_ACTIVE-1
o_y  output  9  pixel row, 0..V_ACTIVE-1
o_active  output  1  1 while the current (h,v) is in the visible region
o_blank  output  1  inverse of o_active
o_line_end  output  1  one-i_clk pulse on horizontal wrap
o_frame_end  output  1  one-i_clk pulse on frame wrap
o_frame_cnt  output  16  frames completed since reset

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 525.
- Internal registers:
  - h_cnt, 10 bits, 0..H_TOTAL-1.
  - v_cnt, 10 bits, 0..V_TOTAL-1.
  - Count 0 is the first visible pixel / line.
- Advance rule, on each i_clk rising edge with i_pix_stb=1:
  - if h_cnt = H_TOTAL-1: h_cnt <= 0 and the line-wrap event occurs.
  - if a line wrap occurs and v_cnt = V_TOTAL-1: v_cnt <= 0 and the frame-wrap event occurs.
  - else if a line wrap occurs: v_cnt <= v_cnt+1.
  - otherwise h_cnt <= h_cnt+1.
- Stall: with i_pix_stb=0, all counters hold and all combinational outputs hold.
- Combinational outputs, zero latency from the counters:
  - o_active = (h_cnt < H_ACTIVE) and (v_cnt < V_ACTIVE); o_blank = not o_active.
  - o_x = h_cnt[9:0] when h_cnt < H_ACTIVE, else 0.
  - o_y = v_cnt[8:0] when v_cnt < V_ACTIVE, else 0.
  - o_hs = SYNC_ACTIVE when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751), else not SYNC_ACTIVE.
  - o_vs = SYNC_ACTIVE when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491), else not SYNC_ACTIVE.
- Registered event outputs:
  - o_line_end = 1 for exactly the single i_clk cycle following the edge on which h_cnt wrapped to 0; otherwise 0.
  - o_frame_end = 1 for the single cycle following the edge on which both counters wrapped to (0,0); o_line_end is also 1 in that cycle.
- Frame counter:
  - o_frame_cnt increments by 1 on the same edge as the frame wrap, so the new value is visible together with o_frame_end.
  - Modulo 2^16: 65535 wraps to 0 with no flag.
- Reset (asynchronous assert, any time including mid-line or mid-frame):
  - h_cnt=0, v_cnt=0, o_frame_cnt=0, o_line_end=0, o_frame_end=0.
  - Hence o_x=0, o_y=0, o_active=1, o_blank=0, o_hs=o_vs=not SYNC_ACTIVE.
  - Counting resumes on the first edge after release where i_pix_stb=1.
- Simultaneous events: an i_pix_stb edge coinciding with i_rst is ignored; reset wins.
- Widths:
  - Counter comparisons use 10-bit unsigned.
  - Parameter sets with H_TOTAL > 1024 or V_TOTAL > 1024 are unsupported.
  - o_y truncation to 9 bits is only valid because V_ACTIVE <= 512.

Test Plan:
- Reset: assert i_rst mid-frame at h=300, v=200 -> immediately o_x=0, o_y=0, o_active=1, o_hs=o_vs=1, o_frame_cnt=0, no event pulses.
- Hsync window: run with i_pix_stb every 4th clk -> o_hs low exactly for h_cnt 656..751 (96 strobes per line); o_active=0 from h=640 to 799; o_x=0 there.
- Line wrap: step to h=799, v=10, next strobe -> h=0, v=11, o_line_end high exactly 1 clk, o_frame_end=0, o_x=0, o_y=11.
- Frame wrap: step to h=799, v=524, next strobe -> (0,0), o_line_end=o_frame_end=1 for one clk, o_frame_cnt 0->1; full frame = 420000 strobes; o_vs low only on lines 490-491.
- Stall: hold i_pix_stb=0 for 50 clks at h=100, v=100 -> o_x=100, o_y=100 and all outputs constant.
- Counter wrap: force 65536 frame wraps (or preload via fast sim) -> o_frame_cnt 65535 -> 0 with normal o_frame_end pulse.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 pixel timing generator.
// Horizontal and vertical counters advance on each pixel strobe. Sync,
// coordinates and active flags are decoded combinationally from them.
// Line/frame event pulses and the frame counter are registered.
module vga_timing_gen #(
    parameter int   H_ACTIVE    = 640,
    parameter int   H_FP        = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BP        = 48,
    parameter int   V_ACTIVE    = 480,
    parameter int   V_FP        = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BP        = 33,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_pix_stb,
    output logic        o_hs,
    output logic        o_vs,
    output logic [9:0]  o_x,
    output logic [8:0]  o_y,
    output logic        o_active,
    output logic        o_blank,
    output logic        o_line_end,
    output logic        o_frame_end,
    output logic [15:0] o_frame_cnt
);

    // Derived totals. Totals above 1024 do not fit the 10-bit counters.
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // All counter comparisons are 10-bit unsigned.
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_STOP  = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_STOP  = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       line_wrap;
    logic       frame_wrap;
    logic       h_vis;
    logic       v_vis;
    logic       h_sync_on;
    logic       v_sync_on;

    // o_y is only 9 bits wide since V_ACTIVE <= 512; the counter MSB is not needed there.
    logic unused_v_msb;
    assign unused_v_msb = v_cnt[9];

    // Wrap events are qualified by the strobe so stalls never generate pulses.
    always_comb begin
        line_wrap  = 1'b0;
        frame_wrap = 1'b0;
        if (i_pix_stb && (h_cnt == H_LAST)) begin
            line_wrap = 1'b1;
            if (v_cnt == V_LAST) begin
                frame_wrap = 1'b1;
            end
        end
    end

    // Horizontal counter: advances per strobe, wraps at the end of each line.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            h_cnt <= '0;
        end else if (line_wrap) begin
            h_cnt <= '0;
        end else if (i_pix_stb) begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    // Vertical counter: steps once per line wrap, wraps at the end of the frame.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            v_cnt <= '0;
        end else if (frame_wrap) begin
            v_cnt <= '0;
        end else if (line_wrap) begin
            v_cnt <= v_cnt + 10'd1;
        end
    end

    // Event pulses last one clock, appearing alongside the wrapped counters.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_line_end  <= 1'b0;
            o_frame_end <= 1'b0;
        end else begin
            o_line_end  <= line_wrap;
            o_frame_end <= frame_wrap;
        end
    end

    // Frames completed since reset; wraps silently modulo 2^16.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_frame_cnt <= '0;
        end else if (frame_wrap) begin
            o_frame_cnt <= o_frame_cnt + 16'd1;
        end
    end

    // Zero-latency decode of coordinates, active region and sync windows.
    always_comb begin
        h_vis     = (h_cnt < H_VIS);
        v_vis     = (v_cnt < V_VIS);
        h_sync_on = (h_cnt >= HS_START) && (h_cnt < HS_STOP);
        v_sync_on = (v_cnt >= VS_START) && (v_cnt < VS_STOP);
        o_active  = h_vis && v_vis;
        o_blank   = !(h_vis && v_vis);
        o_x       = h_vis ? h_cnt : 10'd0;
        o_y       = v_vis ? v_cnt[8:0] : 9'd0;
        o_hs      = h_sync_on ? SYNC_ACTIVE : !SYNC_ACTIVE;
        o_vs      = v_sync_on ? SYNC_ACTIVE : !SYNC_ACTIVE;
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen.
// dut0 uses the standard 640x480 timing; dut1 uses a tiny timing with
// active-high sync so whole frames and frame wraps fit in a short run.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic stb0 = 1'b0;
    logic stb1 = 1'b0;

    logic        hs0, vs0, act0, blk0, le0, fe0;
    logic [9:0]  x0;
    logic [8:0]  y0;
    logic [15:0] fc0;
    logic        hs1, vs1, act1, blk1, le1, fe1;
    logic [9:0]  x1;
    logic [8:0]  y1;
    logic [15:0] fc1;

    int checks = 0;
    int failures = 0;

    // Model parameters: index 0 = dut0, index 1 = dut1
    int p_ha[2]  = '{640, 8};
    int p_hfp[2] = '{16, 2};
    int p_hs[2]  = '{96, 3};
    int p_hbp[2] = '{48, 3};
    int p_va[2]  = '{480, 4};
    int p_vfp[2] = '{10, 1};
    int p_vs[2]  = '{2, 2};
    int p_vbp[2] = '{33, 1};
    bit p_sa[2]  = '{1'b0, 1'b1};

    // Model state
    int mh[2];
    int mv[2];
    int mfc[2];
    bit mle[2];
    bit mfe[2];

    logic [40:0] q0[$];
    logic [40:0] q1[$];

    vga_timing_gen dut0 (
        .i_clk(clk), .i_rst(rst), .i_pix_stb(stb0),
        .o_hs(hs0), .o_vs(vs0), .o_x(x0), .o_y(y0),
        .o_active(act0), .o_blank(blk0), .o_line_end(le0),
        .o_frame_end(fe0), .o_frame_cnt(fc0)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_ACTIVE(1'b1)
    ) dut1 (
        .i_clk(clk), .i_rst(rst), .i_pix_stb(stb1),
        .o_hs(hs1), .o_vs(vs1), .o_x(x1), .o_y(y1),
        .o_active(act1), .o_blank(blk1), .o_line_end(le1),
        .o_frame_end(fe1), .o_frame_cnt(fc1)
    );

    // 100 MHz system clock
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int d);
        mh[d] = 0; mv[d] = 0; mfc[d] = 0; mle[d] = 1'b0; mfe[d] = 1'b0;
    endtask

    task automatic model_step(input int d, input bit s, input bit r);
        int ht;
        int vt;
        ht = p_ha[d] + p_hfp[d] + p_hs[d] + p_hbp[d];
        vt = p_va[d] + p_vfp[d] + p_vs[d] + p_vbp[d];
        if (r) begin
            model_reset(d);
        end else if (s) begin
            mle[d] = (mh[d] == ht - 1);
            mfe[d] = mle[d] && (mv[d] == vt - 1);
            if (mle[d]) begin
                mh[d] = 0;
                mv[d] = mfe[d] ? 0 : mv[d] + 1;
            end else begin
                mh[d] = mh[d] + 1;
            end
            if (mfe[d]) mfc[d] = (mfc[d] + 1) % 65536;
        end else begin
            mle[d] = 1'b0;
            mfe[d] = 1'b0;
        end
    endtask

    function automatic logic [40:0] expect_vec(input int d);
        int h = mh[d];
        int v = mv[d];
        int hs0w = p_ha[d] + p_hfp[d];
        int vs0w = p_va[d] + p_vfp[d];
        logic act, hs, vs;
        logic [9:0] x;
        logic [8:0] y;
        act = (h < p_ha[d]) && (v < p_va[d]);
        x = (h < p_ha[d]) ? 10'(h) : 10'd0;
        y = (v < p_va[d]) ? 9'(v) : 9'd0;
        hs = (h >= hs0w && h < hs0w + p_hs[d]) ? p_sa[d] : ~p_sa[d];
        vs = (v >= vs0w && v < vs0w + p_vs[d]) ? p_sa[d] : ~p_sa[d];
        return {hs, vs, x, y, act, ~act, mle[d], mfe[d], 16'(mfc[d])};
    endfunction

    function automatic logic [40:0] obs0();
        return {hs0, vs0, x0, y0, act0, blk0, le0, fe0, fc0};
    endfunction

    function automatic logic [40:0] obs1();
        return {hs1, vs1, x1, y1, act1, blk1, le1, fe1, fc1};
    endfunction

    // Drive one clock of stimulus, queue the expected outputs, then compare after the edge
    task automatic apply_stimulus(input bit s0, input bit s1, input bit r);
        logic [40:0] e0;
        logic [40:0] e1;
        stb0 = s0;
        stb1 = s1;
        rst  = r;
        model_step(0, s0, r);
        model_step(1, s1, r);
        q0.push_back(expect_vec(0));
        q1.push_back(expect_vec(1));
        @(posedge clk);
        #1;
        e0 = q0.pop_front();
        e1 = q1.pop_front();
        check_output("dut0_outs", 64'(obs0()), 64'(e0));
        check_output("dut1_outs", 64'(obs1()), 64'(e1));
    endtask

    initial begin
        int hs_low_cnt;
        int act_cnt;
        int blank_x0_cnt;
        int first_hs;
        int last_hs;
        int vs_on_cnt;
        int hs_on_cnt;
        int fe_cnt;

        // Power-up reset: outputs must show the reset state immediately
        #1 rst = 1'b1;
        model_reset(0);
        model_reset(1);
        #1;
        check_output("por_dut0", 64'(obs0()), 64'(expect_vec(0)));
        check_output("por_dut1", 64'(obs1()), 64'(expect_vec(1)));
        apply_stimulus(0, 0, 1);
        apply_stimulus(1, 1, 1);
        check_output("rst_wins_x", 64'(x0), 64'd0);
        apply_stimulus(0, 0, 0);

        // Line 0 with a strobe every 4th clock: inspect every horizontal position
        hs_low_cnt = 0; act_cnt = 0; blank_x0_cnt = 0; first_hs = -1; last_hs = -1;
        for (int i = 0; i < 800; i++) begin
            if (hs0 == 1'b0) begin
                hs_low_cnt++;
                if (first_hs < 0) first_hs = i;
                last_hs = i;
            end
            if (act0) act_cnt++;
            if (i >= 640 && x0 == 10'd0 && !act0) blank_x0_cnt++;
            apply_stimulus(1, 0, 0);
            for (int k = 0; k < 3; k++) apply_stimulus(0, 0, 0);
        end
        check_output("hs_low_count", 64'(hs_low_cnt), 64'd96);
        check_output("hs_first", 64'(first_hs), 64'd656);
        check_output("hs_last", 64'(last_hs), 64'd751);
        check_output("active_count", 64'(act_cnt), 64'd640);
        check_output("blank_x_zero", 64'(blank_x0_cnt), 64'd160);
        check_output("line1_y", 64'(y0), 64'd1);

        // Advance to h=799, v=10 and cross the line wrap
        for (int i = 0; i < 9 * 800 + 799; i++) apply_stimulus(1, 0, 0);
        check_output("pre_wrap_xy", 64'({x0, y0, act0}), 64'({10'd0, 9'd10, 1'b0}));
        apply_stimulus(1, 0, 0);
        check_output("wrap_le", 64'(le0), 64'd1);
        check_output("wrap_fe", 64'(fe0), 64'd0);
        check_output("wrap_xy", 64'({x0, y0}), 64'({10'd0, 9'd11}));
        apply_stimulus(0, 0, 0);
        check_output("le_one_clk", 64'(le0), 64'd0);

        // Stall at h=100, v=12
        for (int i = 0; i < 900; i++) apply_stimulus(1, 0, 0);
        for (int i = 0; i < 50; i++) begin
            apply_stimulus(0, 0, 0);
            check_output("stall_xy", 64'({x0, y0, hs0, vs0, act0, le0}),
                         64'({10'd100, 9'd12, 1'b1, 1'b1, 1'b1, 1'b0}));
        end

        // Asynchronous reset mid-line at h=300
        for (int i = 0; i < 200; i++) apply_stimulus(1, 0, 0);
        check_output("pre_rst_x", 64'(x0), 64'd300);
        rst = 1'b1;
        model_reset(0);
        model_reset(1);
        #1;
        check_output("async_rst",
                     64'({x0, y0, act0, blk0, hs0, vs0, le0, fe0, fc0}),
                     64'({10'd0, 9'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0}));
        apply_stimulus(1, 1, 1);
        check_output("rst_stb_ignored", 64'(x0), 64'd0);
        apply_stimulus(0, 0, 0);
        check_output("release_hold_x", 64'(x0), 64'd0);
        apply_stimulus(1, 0, 0);
        check_output("resume_x", 64'(x0), 64'd1);

        // Small-timing frame wrap (16 x 8 = 128 strobes per frame)
        for (int i = 0; i < 127; i++) apply_stimulus(0, 1, 0);
        check_output("d1_no_fe_early", 64'({fe1, fc1}), 64'({1'b0, 16'd0}));
        apply_stimulus(0, 1, 0);
        check_output("d1_frame_wrap",
                     64'({fe1, le1, fc1, x1, y1}),
                     64'({1'b1, 1'b1, 16'd1, 10'd0, 9'd0}));
        apply_stimulus(0, 0, 0);
        check_output("d1_fe_one_clk", 64'({fe1, le1}), 64'd0);

        // One full small frame: count sync positions and frame pulses
        vs_on_cnt = 0; hs_on_cnt = 0; fe_cnt = 0;
        for (int i = 0; i < 128; i++) begin
            if (vs1) vs_on_cnt++;
            if (hs1) hs_on_cnt++;
            apply_stimulus(0, 1, 0);
            if (fe1) fe_cnt++;
        end
        check_output("d1_vs_count", 64'(vs_on_cnt), 64'd32);
        check_output("d1_hs_count", 64'(hs_on_cnt), 64'd24);
        check_output("d1_fe_count", 64'(fe_cnt), 64'd1);
        check_output("d1_fc", 64'(fc1), 64'd2);
        check_output("dut0_fc", 64'(fc0), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
